// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver
//   Drives three PWM outputs for an RGB LED from a 24-bit colour code. Each 8-bit channel
//   sets a duty cycle over a 256-step period of PRESCALE clocks per step. A newly received
//   code is held in a pending buffer. It is applied only at a period boundary, so one
//   period never mixes two duties.
//
// Ports
//   clk               system clock, rising edge
//   rst_n             asynchronous active-low reset
//   rgb_i[23:0]       colour code, [23:16]=R, [15:8]=G, [7:0]=B
//   rgb_valid_i       rgb_i holds a new code this cycle
//   led_r_o/g_o/b_o   registered PWM outputs
//   period_start_o    one-clock pulse in the first clock of each PWM period
//   update_pending_o  a buffered code is waiting for the next period boundary

module rgb_pwm_driver #(
    parameter int unsigned PRESCALE = 4  // clocks per PWM step, 1..65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] rgb_i,
    input  logic        rgb_valid_i,
    output logic        led_r_o,
    output logic        led_g_o,
    output logic        led_b_o,
    output logic        period_start_o,
    output logic        update_pending_o
);

    localparam logic [15:0] PreMax = 16'(PRESCALE - 1);

    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [23:0] pending_q, pending_d;
    logic [23:0] active_q, active_d;
    logic        update_pending_q, update_pending_d;
    logic        led_r_q, led_r_d;
    logic        led_g_q, led_g_d;
    logic        led_b_q, led_b_d;
    logic        period_start_q, period_start_d;

    logic tick;
    logic boundary;

    // With PRESCALE=1, PreMax is 0 and pre_cnt_q never leaves 0, so tick is always high.
    assign tick     = (pre_cnt_q == PreMax);
    assign boundary = tick && (pwm_cnt_q == 8'hFF);

    always_comb begin
        pre_cnt_d        = tick ? 16'd0 : pre_cnt_q + 16'd1;
        pwm_cnt_d        = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        pending_d        = pending_q;
        active_d         = active_q;
        update_pending_d = update_pending_q;

        // rgb_i is only looked at when rgb_valid_i is high, so unknowns on an idle bus stay out.
        if (rgb_valid_i) begin
            pending_d        = rgb_i;
            update_pending_d = 1'b1;
        end

        if (boundary) begin
            update_pending_d = 1'b0;
            if (rgb_valid_i) begin
                // A code arriving on the boundary cycle itself goes straight into the new period.
                active_d = rgb_i;
            end else if (update_pending_q) begin
                active_d = pending_q;
            end
        end

        // Compare against post-edge counter and duty so that all channels lag by one stage.
        led_r_d        = (pwm_cnt_d < active_d[23:16]);
        led_g_d        = (pwm_cnt_d < active_d[15:8]);
        led_b_d        = (pwm_cnt_d < active_d[7:0]);
        period_start_d = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q        <= '0;
            pwm_cnt_q        <= '0;
            pending_q        <= '0;
            active_q         <= '0;
            update_pending_q <= 1'b0;
            led_r_q          <= 1'b0;
            led_g_q          <= 1'b0;
            led_b_q          <= 1'b0;
            period_start_q   <= 1'b0;
        end else begin
            pre_cnt_q        <= pre_cnt_d;
            pwm_cnt_q        <= pwm_cnt_d;
            pending_q        <= pending_d;
            active_q         <= active_d;
            update_pending_q <= update_pending_d;
            led_r_q          <= led_r_d;
            led_g_q          <= led_g_d;
            led_b_q          <= led_b_d;
            period_start_q   <= period_start_d;
        end
    end

    assign led_r_o          = led_r_q;
    assign led_g_o          = led_g_q;
    assign led_b_o          = led_b_q;
    assign period_start_o   = period_start_q;
    assign update_pending_o = update_pending_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Testbench for rgb_pwm_driver: two instances (PRESCALE=1 and PRESCALE=4) share the stimulus.
// The model below tracks which colour code each period should use. At every period boundary
// it pushes that code into a queue. The monitor pops one entry on each period_start pulse. It
// then checks the per-channel high time and the length of the period that just ended.

module tb_rgb_pwm_driver;

    localparam int P0 = 1;
    localparam int P1 = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] rgb = 24'd0;
    logic        rgb_valid = 1'b0;
    logic [1:0]  led_r, led_g, led_b, ps, up;

    int checks = 0;
    int errors = 0;

    rgb_pwm_driver #(.PRESCALE(P0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rgb_i(rgb), .rgb_valid_i(rgb_valid),
        .led_r_o(led_r[0]), .led_g_o(led_g[0]), .led_b_o(led_b[0]),
        .period_start_o(ps[0]), .update_pending_o(up[0])
    );

    rgb_pwm_driver #(.PRESCALE(P1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rgb_i(rgb), .rgb_valid_i(rgb_valid),
        .led_r_o(led_r[1]), .led_g_o(led_g[1]), .led_b_o(led_b[1]),
        .period_start_o(ps[1]), .update_pending_o(up[1])
    );

    always #5 clk = ~clk;

    function automatic int pre(int i);
        return (i == 0) ? P0 : P1;
    endfunction

    function automatic int per(int i);
        return pre(i) * 256;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          cyc = 0;                 // rising edges since reset release
    logic        seen[2] = '{0, 0};       // a code arrived since the last boundary
    logic [23:0] last[2] = '{0, 0};
    logic [23:0] active[2] = '{0, 0};
    logic [23:0] exp_q0[$];
    logic [23:0] exp_q1[$];

    always @(posedge clk) begin
        if (rst_n) begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (rgb_valid) begin
                    last[i] = rgb;
                    seen[i] = 1'b1;
                end
                if (cyc % per(i) == 0) begin
                    if (seen[i]) active[i] = last[i];
                    seen[i] = 1'b0;
                    if (i == 0) exp_q0.push_back(active[i]);
                    else exp_q1.push_back(active[i]);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int          cnt_r[2] = '{0, 0};
    int          cnt_g[2] = '{0, 0};
    int          cnt_b[2] = '{0, 0};
    int          plen[2] = '{0, 0};
    logic        started[2] = '{0, 0};
    logic [23:0] cur[2] = '{0, 0};

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {led_r, led_g, led_b, ps, up}, 0);
        end else begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("period_start[%0d]", i), ps[i], (cyc > 0 && cyc % per(i) == 0));
                chk($sformatf("update_pending[%0d]", i), up[i], seen[i]);
                if (ps[i]) begin
                    if (started[i]) begin
                        chk($sformatf("period_len[%0d]", i), plen[i], per(i));
                        chk($sformatf("r_high[%0d]", i), cnt_r[i], int'(cur[i][23:16]) * pre(i));
                        chk($sformatf("g_high[%0d]", i), cnt_g[i], int'(cur[i][15:8]) * pre(i));
                        chk($sformatf("b_high[%0d]", i), cnt_b[i], int'(cur[i][7:0]) * pre(i));
                    end
                    checks++;
                    if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        errors++;
                        $display("FAIL scoreboard[%0d]: period_start with no expected period", i);
                        cur[i] = 24'd0;
                    end else begin
                        cur[i] = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    end
                    cnt_r[i] = 0;
                    cnt_g[i] = 0;
                    cnt_b[i] = 0;
                    plen[i] = 0;
                    started[i] = 1'b1;
                end
                if (!started[i]) begin
                    chk($sformatf("first_period_leds[%0d]", i), {led_r[i], led_g[i], led_b[i]}, 0);
                end
                cnt_r[i] += int'(led_r[i]);
                cnt_g[i] += int'(led_g[i]);
                cnt_b[i] += int'(led_b[i]);
                plen[i]++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        rgb_valid = 1'b0;
        #1;
        chk("async_reset_leds", {led_r, led_g, led_b}, 0);
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            seen[i] = 1'b0;
            last[i] = 24'd0;
            active[i] = 24'd0;
            started[i] = 1'b0;
        end
        exp_q0.delete();
        exp_q1.delete();
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Caller is at a falling edge; the code is sampled at the next rising edge.
    task automatic send(logic [23:0] code);
        rgb = code;
        rgb_valid = 1'b1;
        @(negedge clk);
        rgb_valid = 1'b0;
        rgb = 24'($urandom);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            rgb = 24'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        do_reset();
        idle(600);

        idle(100);
        send(24'hFF8000);
        idle(2200);

        idle(40);
        send(24'h100000);
        idle(50);
        send(24'h000020);
        idle(2200);

        // Code arriving exactly on a PRESCALE=1 boundary while another is pending.
        send(24'h101010);
        for (int k = 0; k < 300 && ((cyc + 1) % per(0)) != 0; k++) idle(1);
        checks++;
        if (((cyc + 1) % per(0)) != 0) begin
            errors++;
            $display("FAIL boundary_wait: got cyc %0d, expected boundary next", cyc);
        end
        send(24'h404040);
        idle(2200);

        send(24'h010000);
        idle(2200);

        send(24'hFFFFFF);
        idle(2200 + 300);
        do_reset();
        idle(2300);

        for (int k = 0; k < 20000; k++) begin
            if ($urandom_range(0, 299) == 0) send(24'($urandom));
            else idle(1);
        end
        idle(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
- Downstream stage of the colour converter: consumes the 24-bit RGB code read from the colour memory and drives three PWM outputs for an RGB LED.
- Each 8-bit channel sets a duty cycle over a 256-step PWM period.
- New codes are buffered and only applied at a period boundary, so a period never mixes old and new duties and no output glitches.

Parameters:
- PRESCALE, 4: clocks per PWM step; legal range 1..65535. PWM period = 256*PRESCALE clocks.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- rgb  input  24  colour code; [23:16]=R, [15:8]=G, [7:0]=B
- rgb_valid  input  1  rgb holds a new code this cycle; the integrating top drives it with the converter's enable delayed one clock (memory read latency 1)
- led_r  output  1  red PWM, registered
- led_g  output  1  green PWM, registered
- led_b  output  1  blue PWM, registered
- period_start  output  1  one-clock pulse in the first clock of each PWM period
- update_pending  output  1  a buffered code is waiting for the next period boundary

Behaviour:
- Reset (rst_n low, asynchronous):
  - led_r/g/b=0, period_start=0, update_pending=0.
  - Prescale counter=0, pwm_cnt=0, pending and active duty registers=0.
  - Reset may assert at any time, including mid-period; all state clears immediately.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 and wraps.
  - tick=1 when pre_cnt==PRESCALE-1. With PRESCALE=1, tick is constant 1.
- PWM counter:
  - pwm_cnt (8 bit) increments on tick and wraps 255->0.
  - Boundary cycle = tick && pwm_cnt==255.
- Capture:
  - On rgb_valid, pending <= rgb and update_pending <= 1.
  - If several rgb_valid arrive within one period, the last one wins.
- Load at the boundary cycle:
  - If rgb_valid is also high that cycle, active <= rgb (bypass) and pending <= rgb.
  - Else, if update_pending, active <= pending.
  - update_pending <= 0 in both cases.
  - If neither holds, active is unchanged.
  - rgb_valid outside the boundary cycle never touches active.
- Outputs, registered each clock:
  - led_r <= (pwm_cnt < active_r), computed using the pwm_cnt and active values after the current edge's update. Net effect: output lags the counter by one register stage, consistently for all channels. Same for g and b.
  - Duty 0: output always 0.
  - Duty N: output high for N*PRESCALE clocks per period.
  - Duty 255: output high for 255 of 256 steps (never fully on).
- period_start <= 1 for exactly one clock following each boundary edge; 0 otherwise. The first period after reset does not pulse.
- Arithmetic: all comparisons unsigned 8 bit. The prescale counter width is sufficient for PRESCALE-1 (16 bit).
- rgb is sampled only when rgb_valid=1. X on rgb when rgb_valid=0 must not propagate.

Test Plan:
- Reset then idle, PRESCALE=1, 600 clocks, no rgb_valid -> all leds stay 0; period_start pulses at clocks 257 and 513 after reset release; update_pending=0.
- rgb=0xFF8000 with rgb_valid mid-period -> update_pending=1 until the next boundary; from the next period on, led_r high 255, led_g high 128, led_b high 0 clocks out of every 256.
- Two rgb_valid in one period (0x100000 then 0x000020) -> next period applies only the second: led_r=0, led_b high 32 clocks.
- rgb_valid asserted exactly on the boundary cycle with 0x404040 while pending holds 0x101010 -> new period uses 0x40 (64-clock highs); update_pending=0 afterwards.
- PRESCALE=4, rgb=0x010000 -> period 1024 clocks; led_r high exactly 4 clocks per period.
- rst_n pulsed low mid-period while active=0xFFFFFF -> leds drop to 0 asynchronously; after release, leds remain 0 until a new code is loaded at a boundary.
